// File: rtl/regfile_context_streamer_if.sv
// Save (master) and restore (slave) ready/valid streams of the register-file context streamer.
interface regfile_context_streamer_if #(
  parameter int unsigned size = 32
) ();
  logic            m_valid;
  logic            m_ready;
  logic [size-1:0] m_data;
  logic            m_last;
  logic            s_valid;
  logic            s_ready;
  logic [size-1:0] s_data;
  logic            s_last;

  modport master (
    output m_valid, m_data, m_last, s_ready,
    input  m_ready, s_valid, s_data, s_last
  );

  modport slave (
    input  m_valid, m_data, m_last, s_ready,
    output m_ready, s_valid, s_data, s_last
  );
endinterface

// File: rtl/regfile_context_streamer.sv
// Spills a CGRA register file out on a save stream, or reloads it from a restore stream.
// Save path: 1-cycle-latency reads feed a 3-entry skid FIFO gated by registered credit.
module regfile_context_streamer #(
  parameter int unsigned log2regs = 3,
  parameter int unsigned size     = 32
) (
  input  logic                CGRA_Clock,
  input  logic                CGRA_Reset,
  input  logic                save_start,
  input  logic                restore_start,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [log2regs-1:0] rf_address_out,
  input  logic [size-1:0]     rf_data_in,
  output logic                rf_WE,
  output logic [log2regs-1:0] rf_address_in,
  output logic [size-1:0]     rf_data_out,
  regfile_context_streamer_if.master strm
);

  typedef enum logic [1:0] {
    IDLE,
    SAVE,
    RESTORE
  } state_t;

  localparam logic [log2regs:0] LAST_IDX = {1'b0, {log2regs{1'b1}}};
  localparam logic [log2regs:0] IDX_ONE  = {{log2regs{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic                start_acc, issue, push, pop, beat, finish;
  logic [log2regs:0]   rd_idx_q, wr_idx_q;
  logic [log2regs-1:0] rd_addr_q;
  logic                rd_pend_q, rd_last_q;
  logic [size:0]       fifo_mem [3];
  logic [1:0]          head_q, tail_q, cnt_q;
  logic [2:0]          credit;
  logic                head_last, last_hit;
  logic                done_q, error_q, we_q;
  logic [log2regs-1:0] wr_addr_q;
  logic [size-1:0]     wr_data_q;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit counts words stored plus the read in flight, all registered,
  // so issue never depends on m_ready in the same cycle.
  assign credit    = {1'b0, cnt_q} + {2'b00, rd_pend_q};
  assign head_last = fifo_mem[head_q][size];
  assign last_hit  = (wr_idx_q == LAST_IDX);

  always_ff @(posedge CGRA_Clock) begin
    if (CGRA_Reset) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    issue     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    beat      = 1'b0;
    finish    = 1'b0;
    case (state_q)
      IDLE: begin
        if (save_start) begin
          state_d   = SAVE;
          start_acc = 1'b1;
        end else if (restore_start) begin
          state_d   = RESTORE;
          start_acc = 1'b1;
        end
      end
      SAVE: begin
        issue = !rd_idx_q[log2regs] && (credit < 3'd3);
        push  = rd_pend_q;
        pop   = (cnt_q != 2'd0) && strm.m_ready;
        if (pop && head_last) begin
          state_d = IDLE;
          finish  = 1'b1;
        end
      end
      RESTORE: begin
        beat = strm.s_valid;
        if (beat && last_hit) begin
          state_d = IDLE;
          finish  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CGRA_Clock) begin
    if (CGRA_Reset) begin
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      we_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_idx_q  <= '0;
      wr_idx_q  <= '0;
      rd_addr_q <= '0;
      rd_pend_q <= 1'b0;
      rd_last_q <= 1'b0;
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
      for (int unsigned i = 0; i < 3; i++) fifo_mem[i] <= '0;
    end else begin
      done_q <= finish;
      we_q   <= beat;
      if (start_acc) begin
        error_q   <= 1'b0;
        rd_idx_q  <= '0;
        wr_idx_q  <= '0;
        rd_pend_q <= 1'b0;
        rd_last_q <= 1'b0;
        head_q    <= '0;
        tail_q    <= '0;
        cnt_q     <= '0;
      end else begin
        rd_pend_q <= issue;
        if (issue) begin
          rd_idx_q  <= rd_idx_q + IDX_ONE;
          rd_addr_q <= rd_idx_q[log2regs-1:0];
          rd_last_q <= (rd_idx_q == LAST_IDX);
        end
        if (push) begin
          fifo_mem[tail_q] <= {rd_last_q, rf_data_in};
          tail_q           <= ptr_inc(tail_q);
        end
        if (pop) head_q <= ptr_inc(head_q);
        case ({push, pop})
          2'b10:   cnt_q <= cnt_q + 2'd1;
          2'b01:   cnt_q <= cnt_q - 2'd1;
          default: cnt_q <= cnt_q;
        endcase
        // The word is written even when its framing is wrong; only the flag records it.
        if (beat) begin
          wr_idx_q  <= wr_idx_q + IDX_ONE;
          wr_addr_q <= wr_idx_q[log2regs-1:0];
          wr_data_q <= strm.s_data;
          if (strm.s_last != last_hit) error_q <= 1'b1;
        end
      end
    end
  end

  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign error          = error_q;
  assign rf_address_out = issue ? rd_idx_q[log2regs-1:0] : rd_addr_q;
  assign rf_WE          = we_q;
  assign rf_address_in  = wr_addr_q;
  assign rf_data_out    = wr_data_q;
  assign strm.m_valid   = (cnt_q != 2'd0);
  assign strm.m_data    = fifo_mem[head_q][size-1:0];
  assign strm.m_last    = head_last;
  assign strm.s_ready   = (state_q == RESTORE);

endmodule

// File: tb/tb_regfile_context_streamer.sv
// Directed bench for regfile_context_streamer with an 8x32 registered-read regfile model.
module tb_regfile_context_streamer;
  localparam int unsigned LOG2 = 3;
  localparam int unsigned W    = 32;
  localparam int unsigned N    = 8;

  logic            CGRA_Clock = 1'b0;
  logic            CGRA_Reset = 1'b1;
  logic            save_start = 1'b0;
  logic            restore_start = 1'b0;
  logic            busy, done, error, rf_WE;
  logic [LOG2-1:0] rf_address_out, rf_address_in;
  logic [W-1:0]    rf_data_in, rf_data_out;
  int              errors = 0;
  int              checks = 0;

  logic [W-1:0]    rf_mem [N];
  logic            pl_go = 1'b0;
  logic [W-1:0]    pl_base = '0;

  regfile_context_streamer_if #(.size(W)) strm ();

  regfile_context_streamer #(.log2regs(LOG2), .size(W)) dut (
    .CGRA_Clock     (CGRA_Clock),
    .CGRA_Reset     (CGRA_Reset),
    .save_start     (save_start),
    .restore_start  (restore_start),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .rf_address_out (rf_address_out),
    .rf_data_in     (rf_data_in),
    .rf_WE          (rf_WE),
    .rf_address_in  (rf_address_in),
    .rf_data_out    (rf_data_out),
    .strm           (strm)
  );

  always #5 CGRA_Clock = ~CGRA_Clock;

  always @(posedge CGRA_Clock) begin
    if (pl_go) begin
      for (int unsigned i = 0; i < N; i++) rf_mem[i] <= pl_base + W'(i);
    end else if (rf_WE) begin
      rf_mem[rf_address_in] <= rf_data_out;
    end
    rf_data_in <= rf_mem[rf_address_out];
  end

  task automatic tick();
    @(posedge CGRA_Clock);
    #1;
  endtask

  task automatic preload(input logic [W-1:0] base);
    pl_base = base;
    pl_go   = 1'b1;
    tick();
    pl_go   = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] ctl;
    CGRA_Reset = 1'b1;
    strm.m_ready = 1'b0;
    strm.s_valid = 1'b0;
    strm.s_data  = '0;
    strm.s_last  = 1'b0;
    tick();
    tick();
    ctl = {busy, done, error, rf_WE, strm.m_valid, strm.m_last, strm.s_ready};
    checks++;
    if (ctl !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctl: busy/done/error/rf_WE/m_valid/m_last/s_ready got %b want 0000000", ctl);
    end
    checks++;
    if ({rf_address_out, rf_address_in, rf_data_out, strm.m_data} !== {(2*LOG2+2*W){1'b0}}) begin
      errors++;
      $display("FAIL reset_data: raddr=%0d waddr=%0d wdata=%h m_data=%h want all 0",
               rf_address_out, rf_address_in, rf_data_out, strm.m_data);
    end
    CGRA_Reset = 1'b0;
    tick();
    ctl = {busy, done, error, rf_WE, strm.m_valid, strm.m_last, strm.s_ready};
    checks++;
    if (ctl !== 7'b0) begin
      errors++;
      $display("FAIL reset_idle: ctl got %b want 0000000", ctl);
    end
  endtask

  task automatic test_save_basic();
    logic [3:0] obs, exp;
    preload(32'h100);
    strm.m_ready = 1'b1;
    save_start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      save_start = 1'b0;
      obs = {busy, done, strm.m_valid, strm.m_last};
      exp = {1'(c >= 1 && c <= 10), 1'(c == 11), 1'(c >= 3 && c <= 10), 1'(c == 10)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL save_ctl cycle %0d: busy/done/m_valid/m_last got %b want %b", c, obs, exp);
      end
      if (c == 1) begin
        checks++;
        if (rf_address_out !== 3'd0) begin
          errors++;
          $display("FAIL save_first_read: rf_address_out got %0d want 0", rf_address_out);
        end
      end
      if (c >= 3 && c <= 10) begin
        checks++;
        if (strm.m_data !== 32'h100 + W'(c - 3)) begin
          errors++;
          $display("FAIL save_data cycle %0d: m_data got %h want %h", c, strm.m_data, 32'h100 + W'(c - 3));
        end
      end
    end
  endtask

  task automatic test_save_backpressure();
    logic [3:0]   pat;
    logic [W-1:0] prev_d;
    logic         prev_stall;
    int           popped, issued;
    bit           got_done;
    pat = 4'b1001;
    popped = 0;
    issued = 0;
    prev_stall = 1'b0;
    prev_d = '0;
    got_done = 1'b0;
    strm.m_ready = 1'b0;
    save_start = 1'b1;
    for (int c = 1; c <= 60 && !got_done; c++) begin
      tick();
      save_start = 1'b0;
      strm.m_ready = pat[c % 4];
      if (issued < 8 && rf_address_out == issued[2:0]) issued++;
      checks++;
      if (issued - popped > 3) begin
        errors++;
        $display("FAIL bp_outstanding cycle %0d: outstanding got %0d want <=3", c, issued - popped);
      end
      if (prev_stall) begin
        checks++;
        if (strm.m_data !== prev_d) begin
          errors++;
          $display("FAIL bp_stable cycle %0d: m_data got %h want %h", c, strm.m_data, prev_d);
        end
      end
      if (strm.m_valid && strm.m_ready) begin
        checks++;
        if ({strm.m_last, strm.m_data} !== {1'(popped == 7), 32'h100 + W'(popped)}) begin
          errors++;
          $display("FAIL bp_word %0d: last/data got %b/%h want %b/%h", popped, strm.m_last,
                   strm.m_data, popped == 7, 32'h100 + W'(popped));
        end
        popped++;
      end
      prev_stall = strm.m_valid && !strm.m_ready;
      prev_d = strm.m_data;
      if (done) got_done = 1'b1;
    end
    checks++;
    if (!got_done || popped != 8 || issued != 8) begin
      errors++;
      $display("FAIL bp_complete: done=%0d popped=%0d issued=%0d want 1/8/8", got_done, popped, issued);
    end
    strm.m_ready = 1'b0;
  endtask

  task automatic test_restore(input logic [W-1:0] base, input logic [11:0] vpat, input int last_at);
    int              beats;
    logic            exp_we, exp_done, exp_err;
    logic [LOG2-1:0] exp_a;
    logic [W-1:0]    exp_d;
    logic [4:0]      obs_c, exp_c;
    bit              fin;
    beats = 0;
    exp_we = 1'b0;
    exp_done = 1'b0;
    exp_err = 1'b0;
    exp_a = '0;
    exp_d = '0;
    fin = 1'b0;
    strm.s_valid = 1'b0;
    restore_start = 1'b1;
    for (int c = 1; c <= 40 && !fin; c++) begin
      tick();
      restore_start = 1'b0;
      obs_c = {busy, done, error, strm.s_ready, rf_WE};
      exp_c = {1'(beats < 8), exp_done, exp_err, 1'(beats < 8), exp_we};
      checks++;
      if (obs_c !== exp_c) begin
        errors++;
        $display("FAIL restore_ctl cycle %0d: busy/done/error/s_ready/rf_WE got %b want %b", c, obs_c, exp_c);
      end
      if (exp_we) begin
        checks++;
        if ({rf_address_in, rf_data_out} !== {exp_a, exp_d}) begin
          errors++;
          $display("FAIL restore_write cycle %0d: addr/data got %0d/%h want %0d/%h", c,
                   rf_address_in, rf_data_out, exp_a, exp_d);
        end
      end
      fin = exp_done;
      exp_we = 1'b0;
      exp_done = 1'b0;
      if (beats < 8) begin
        strm.s_valid = vpat[c % 12];
        strm.s_data  = base + W'(beats);
        strm.s_last  = (beats == last_at);
        if (strm.s_valid) begin
          exp_we = 1'b1;
          exp_a = LOG2'(beats);
          exp_d = strm.s_data;
          if ((beats == last_at) != (beats == 7)) exp_err = 1'b1;
          exp_done = (beats == 7);
          beats++;
        end
      end else begin
        strm.s_valid = 1'b0;
      end
    end
    strm.s_valid = 1'b0;
    strm.s_last = 1'b0;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL restore_timeout: done not seen, beats=%0d want 8", beats);
    end
    tick();
    checks++;
    if ({rf_WE, done, busy, error} !== {3'b000, exp_err}) begin
      errors++;
      $display("FAIL restore_after: rf_WE/done/busy/error got %b want %b", {rf_WE, done, busy, error},
               {3'b000, exp_err});
    end
  endtask

  task automatic test_error_clear();
    int popped;
    bit got_done;
    popped = 0;
    got_done = 1'b0;
    strm.m_ready = 1'b1;
    save_start = 1'b1;
    tick();
    save_start = 1'b0;
    checks++;
    if ({error, busy} !== 2'b01) begin
      errors++;
      $display("FAIL error_clear: error/busy got %b want 01", {error, busy});
    end
    for (int c = 2; c <= 20 && !got_done; c++) begin
      tick();
      if (strm.m_valid) begin
        checks++;
        if (strm.m_data !== 32'hB0 + W'(popped)) begin
          errors++;
          $display("FAIL error_readback %0d: m_data got %h want %h", popped, strm.m_data, 32'hB0 + W'(popped));
        end
        popped++;
      end
      if (done) got_done = 1'b1;
    end
    checks++;
    if (!got_done || popped != 8) begin
      errors++;
      $display("FAIL error_readback_count: done=%0d words=%0d want 1/8", got_done, popped);
    end
  endtask

  task automatic test_both_starts();
    logic [5:0] obs, exp;
    preload(32'h200);
    strm.m_ready = 1'b1;
    save_start = 1'b1;
    restore_start = 1'b1;
    strm.s_valid = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      save_start = 1'b0;
      restore_start = (c == 2);
      obs = {busy, done, strm.m_valid, strm.m_last, strm.s_ready, rf_WE};
      exp = {1'(c <= 10), 1'(c == 11), 1'(c >= 3 && c <= 10), 1'(c == 10), 2'b00};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL both_ctl cycle %0d: busy/done/m_valid/m_last/s_ready/rf_WE got %b want %b", c, obs, exp);
      end
      if (c >= 3 && c <= 10) begin
        checks++;
        if (strm.m_data !== 32'h200 + W'(c - 3)) begin
          errors++;
          $display("FAIL both_data cycle %0d: m_data got %h want %h", c, strm.m_data, 32'h200 + W'(c - 3));
        end
      end
    end
    strm.s_valid = 1'b0;
    restore_start = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [6:0] ctl;
    int         popped;
    bit         got_done;
    preload(32'h100);
    strm.m_ready = 1'b1;
    save_start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      save_start = 1'b0;
    end
    strm.m_ready = 1'b0;
    CGRA_Reset = 1'b1;
    tick();
    ctl = {busy, done, error, rf_WE, strm.m_valid, strm.m_last, strm.s_ready};
    checks++;
    if (ctl !== 7'b0 || {rf_address_out, rf_address_in, rf_data_out, strm.m_data} !== {(2*LOG2+2*W){1'b0}}) begin
      errors++;
      $display("FAIL midreset_outputs: ctl=%b raddr=%0d waddr=%0d wdata=%h m_data=%h want all 0",
               ctl, rf_address_out, rf_address_in, rf_data_out, strm.m_data);
    end
    CGRA_Reset = 1'b0;
    tick();
    checks++;
    if ({busy, done, strm.m_valid} !== 3'b000) begin
      errors++;
      $display("FAIL midreset_idle: busy/done/m_valid got %b want 000", {busy, done, strm.m_valid});
    end
    popped = 0;
    got_done = 1'b0;
    strm.m_ready = 1'b1;
    save_start = 1'b1;
    for (int c = 1; c <= 20 && !got_done; c++) begin
      tick();
      save_start = 1'b0;
      if (strm.m_valid) begin
        checks++;
        if (strm.m_data !== 32'h100 + W'(popped)) begin
          errors++;
          $display("FAIL midreset_resave %0d: m_data got %h want %h", popped, strm.m_data, 32'h100 + W'(popped));
        end
        popped++;
      end
      if (done) got_done = 1'b1;
    end
    checks++;
    if (!got_done || popped != 8) begin
      errors++;
      $display("FAIL midreset_resave_count: done=%0d words=%0d want 1/8", got_done, popped);
    end
  endtask

  initial begin
    test_reset();
    test_save_basic();
    test_save_backpressure();
    test_restore(32'hA0, 12'b1101_1011_0110, 7);
    test_restore(32'hB0, 12'hFFF, 2);
    test_error_clear();
    test_both_starts();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
